// File: rtl/string_hw_pkg.sv
// Shared definitions for the string hardware FIFO sequencer: register map,
// opcode/state enums, CTRL/STATUS bit positions and the per-character transform.
package string_hw_pkg;

  localparam logic [2:0] CTRL_A    = 3'd0;
  localparam logic [2:0] STATUS_A  = 3'd1;
  localparam logic [2:0] CHARCNT_A = 3'd2;
  localparam logic [2:0] LIMIT_A   = 3'd3;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_OP_LSB = 1;
  localparam int unsigned CTRL_ABORT  = 3;
  localparam int unsigned CTRL_IRQ_EN = 4;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_NUL  = 2;

  typedef enum logic [1:0] {
    OP_PASS   = 2'd0,
    OP_UPPER  = 2'd1,
    OP_LOWER  = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_XFORM,
    S_STORE,
    S_DONE
  } state_e;

  // ASCII letters differ from their other case only in bit 5.
  function automatic logic [7:0] xform_char(input logic [7:0] c, input op_e op);
    logic is_up;
    logic is_lo;
    is_up = (c >= 8'h41) && (c <= 8'h5A);
    is_lo = (c >= 8'h61) && (c <= 8'h7A);
    xform_char = c;
    case (op)
      OP_UPPER:  if (is_lo) xform_char = c & 8'hDF;
      OP_LOWER:  if (is_up) xform_char = c | 8'h20;
      OP_TOGGLE: if (is_up || is_lo) xform_char = c ^ 8'h20;
      default:   xform_char = c;
    endcase
  endfunction

endpackage

// File: rtl/string_hw_seq_ctrl_byte_xform.sv
// Combinational lane transform: bytes scanned MSB first, everything from the
// first NUL onward is forced to zero and excluded from the prefix length.
module string_hw_byte_xform
  import string_hw_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned LANES = DATA_W / 8,
  localparam int unsigned LEN_W = $clog2(LANES + 1)
) (
  input  logic [DATA_W-1:0] word,
  input  op_e               opcode,
  output logic [DATA_W-1:0] xword,
  output logic              nul_seen,
  output logic [LEN_W-1:0]  prefix_len
);

  logic [7:0] c;

  always_comb begin
    xword      = '0;
    nul_seen   = 1'b0;
    prefix_len = '0;
    c          = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      c = word[DATA_W-1-8*i -: 8];
      if (c == 8'h00) nul_seen = 1'b1;
      if (!nul_seen) begin
        xword[DATA_W-1-8*i -: 8] = xform_char(c, opcode);
        prefix_len = prefix_len + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/string_hw_seq_ctrl.sv
// Avalon-MM controlled sequencer moving words from the input string FIFO through
// the byte transform into the output FIFO. Optional IRQ: define STRHW_SEQ_IRQ_EN.
module string_hw_seq_ctrl
  import string_hw_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_fifo_data,
  input  logic              in_fifo_empty,
  output logic              in_fifo_rd,
  output logic [DATA_W-1:0] out_fifo_data,
  input  logic              out_fifo_full,
  output logic              out_fifo_wr,
  output logic              irq
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned LEN_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] LIMIT_MAX = CNT_W'(MAX_WORDS);

  state_e            state, state_nx;
  op_e               opcode;
  logic [CNT_W-1:0]  limit;
  logic [CNT_W-1:0]  char_count;
  logic [CNT_W-1:0]  word_count;
  logic              done, busy, nul_seen;
  logic [DATA_W-1:0] in_word;
  logic              irq_en_rd;

  logic              wr_ctrl, wr_status, wr_limit;
  logic              go, abort, last_word;
  logic [DATA_W-1:0] xf_word;
  logic              xf_nul;
  logic [LEN_W-1:0]  xf_len;
  logic [CNT_W:0]    cc_sum;
  logic [CNT_W-1:0]  cc_next;

  assign wr_ctrl   = chipselect && write && (address == CTRL_A);
  assign wr_status = chipselect && write && (address == STATUS_A);
  assign wr_limit  = chipselect && write && (address == LIMIT_A);
  assign abort     = wr_ctrl && writedata[CTRL_ABORT];
  assign go        = wr_ctrl && writedata[CTRL_GO] && !writedata[CTRL_ABORT];
  assign last_word = (word_count + CNT_W'(1)) == limit;

  assign cc_sum  = {1'b0, char_count} + (CNT_W+1)'(xf_len);
  assign cc_next = cc_sum[CNT_W] ? '1 : cc_sum[CNT_W-1:0];

  string_hw_byte_xform #(.DATA_W(DATA_W)) u_xform (
    .word       (in_word),
    .opcode     (opcode),
    .xword      (xf_word),
    .nul_seen   (xf_nul),
    .prefix_len (xf_len)
  );

  always_comb begin
    state_nx    = state;
    in_fifo_rd  = 1'b0;
    out_fifo_wr = 1'b0;
    case (state)
      S_IDLE:  if (go) state_nx = S_FETCH;
      S_FETCH: if (!in_fifo_empty) begin
        in_fifo_rd = 1'b1;
        state_nx   = S_XFORM;
      end
      S_XFORM: state_nx = S_STORE;
      S_STORE: if (!out_fifo_full) begin
        out_fifo_wr = 1'b1;
        state_nx    = (nul_seen || last_word) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // A push already on the bus in the abort cycle is allowed to complete.
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      opcode        <= OP_PASS;
      limit         <= LIMIT_MAX;
      char_count    <= '0;
      word_count    <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      nul_seen      <= 1'b0;
      in_word       <= '0;
      out_fifo_data <= '0;
    end else begin
      state <= state_nx;
      if (wr_status) begin
        done     <= 1'b0;
        nul_seen <= 1'b0;
      end
      if (wr_limit && !busy)
        limit <= ((writedata == '0) || (writedata > MAX_WORDS)) ? LIMIT_MAX
                                                                 : writedata[CNT_W-1:0];
      if (wr_ctrl && !busy) opcode <= op_e'(writedata[CTRL_OP_LSB +: 2]);
      if (abort && (state != S_IDLE)) begin
        busy <= 1'b0;
        done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (go) begin
            char_count <= '0;
            word_count <= '0;
            done       <= 1'b0;
            nul_seen   <= 1'b0;
            busy       <= 1'b1;
          end
          S_FETCH: if (!in_fifo_empty) in_word <= in_fifo_data;
          S_XFORM: begin
            out_fifo_data <= xf_word;
            char_count    <= cc_next;
            if (xf_nul) nul_seen <= 1'b1;
          end
          S_STORE: if (!out_fifo_full) word_count <= word_count + CNT_W'(1);
          S_DONE: begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STRHW_SEQ_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
      irq <= done && irq_en;
    end
  end

  assign irq_en_rd = irq_en;
`else
  assign irq       = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        CTRL_A:    readdata = {27'd0, irq_en_rd, 1'b0, opcode, 1'b0};
        STATUS_A:  readdata = {29'd0, nul_seen, done, busy};
        CHARCNT_A: readdata = 32'(char_count);
        LIMIT_A:   readdata = 32'(limit);
        default:   readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_string_hw_seq_ctrl.sv
// Directed bench for string_hw_seq_ctrl with a word-level reference model of
// the character transform and job termination rules.
module tb_string_hw_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [31:0] in_fifo_data;
  logic        in_fifo_empty, in_fifo_rd;
  logic [31:0] out_fifo_data;
  logic        out_fifo_full, out_fifo_wr;
  logic        irq;

  string_hw_seq_ctrl #(.DATA_W(32), .CNT_W(16), .MAX_WORDS(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .address       (address),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .readdata      (readdata),
    .in_fifo_data  (in_fifo_data),
    .in_fifo_empty (in_fifo_empty),
    .in_fifo_rd    (in_fifo_rd),
    .out_fifo_data (out_fifo_data),
    .out_fifo_full (out_fifo_full),
    .out_fifo_wr   (out_fifo_wr),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] inq[$];
  logic [31:0] outq[$];
  logic [31:0] expq[$];
  logic [31:0] src[$];
  int          exp_cc;
  bit          exp_nul;
  int          cur_lim;
  logic        s_rd = 1'b0, s_wr = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [31:0] d, st;
  logic        irq_at_done;
  int unsigned k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic upd();
    in_fifo_empty = (inq.size() == 0);
    in_fifo_data  = (inq.size() != 0) ? inq[0] : 32'h0;
  endtask

  // Reference: MSB char first, letters shifted by 32 per opcode, NUL kills the rest.
  function automatic logic [31:0] m_word(input logic [31:0] w, input int op,
                                         output bit nul, output int len);
    logic [7:0]  ch;
    logic [31:0] r;
    r = 32'h0; nul = 1'b0; len = 0;
    for (int i = 3; i >= 0; i--) begin
      ch = w[i*8 +: 8];
      if (ch == 8'h00) nul = 1'b1;
      if (nul) ch = 8'h00;
      else begin
        len++;
        if ((op == 1 || op == 3) && ch >= "a" && ch <= "z") ch = ch - 8'd32;
        else if ((op == 2 || op == 3) && ch >= "A" && ch <= "Z") ch = ch + 8'd32;
      end
      r[i*8 +: 8] = ch;
    end
    return r;
  endfunction

  task automatic model_job(input int op, input int lim);
    bit          nul;
    int          len;
    logic [31:0] r;
    exp_cc = 0; exp_nul = 1'b0;
    for (int i = 0; i < src.size() && i < lim; i++) begin
      r = m_word(src[i], op, nul, len);
      expq.push_back(r);
      exp_cc += len;
      if (nul) begin
        exp_nul = 1'b1;
        break;
      end
    end
  endtask

  task automatic feed();
    foreach (src[i]) inq.push_back(src[i]);
    upd();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] v);
    @(posedge clk); #2;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
    @(posedge clk); #2;
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
    @(posedge clk); #2;
    chipselect = 1'b1; read = 1'b1; address = a;
    #2 v = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic set_limit(input int v);
    wr_reg(3'd3, v);
    cur_lim = (v == 0 || v > 64) ? 64 : v;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] s;
    int unsigned n;
    s = '0; n = 0;
    while (!s[1] && n < 300) begin
      rd_reg(3'd1, s);
      n++;
    end
    if (!s[1]) begin
      n_checks++;
      $display("FAIL %s_timeout: done=0 after %0d polls, required done=1", name, n);
    end
  endtask

  always @(negedge clk) begin : compare
    s_rd = in_fifo_rd; s_wr = out_fifo_wr; s_wdata = out_fifo_data;
    if (!reset) begin
      if (in_fifo_empty) check("no_pop_when_empty", {31'd0, in_fifo_rd}, 32'd0);
      if (out_fifo_full) check("no_push_when_full", {31'd0, out_fifo_wr}, 32'd0);
`ifndef STRHW_SEQ_IRQ_EN
      check("irq_tied_low", {31'd0, irq}, 32'd0);
`endif
      if (out_fifo_wr) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_push: got push of 0x%08h, required no push", out_fifo_data);
        end else check("push_data", out_fifo_data, expq.pop_front());
      end
    end
  end

  always @(posedge clk) begin : fifo_model
    #1;
    if (s_rd && inq.size() > 0) void'(inq.pop_front());
    if (s_wr) outq.push_back(s_wdata);
    upd();
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; out_fifo_full = 1'b0; cur_lim = 64;
    upd();
    tick(3);
    @(negedge clk);
    check("rst_in_fifo_rd", {31'd0, in_fifo_rd}, 32'd0);
    check("rst_out_fifo_wr", {31'd0, out_fifo_wr}, 32'd0);
    check("rst_out_fifo_data", out_fifo_data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    rd_reg(3'd0, d); check("rst_ctrl", d, 32'h0);
    rd_reg(3'd1, d); check("rst_status", d, 32'h0);
    rd_reg(3'd2, d); check("rst_charcnt", d, 32'h0);
    rd_reg(3'd3, d); check("rst_limit", d, 32'd64);

    // Uppercase over four words, job ends on the word limit.
    set_limit(4);
    src = '{"abcd", "1234", "5z7x", "BEEF"};
    model_job(1, cur_lim); outq.delete(); feed();
    wr_reg(3'd0, 32'h3);
    wait_done("job1");
    rd_reg(3'd1, d); check("job1_status", d, {29'd0, exp_nul, 1'b1, 1'b0});
    rd_reg(3'd2, d); check("job1_charcnt", d, 32'd16);
    check("job1_pushes", outq.size(), 32'd4);
    check("job1_out0", outq[0], "ABCD");
    check("job1_out2", outq[2], "5Z7X");
    check("job1_out3", outq[3], "BEEF");

    // Limit clamping, then lowercase stopping at an embedded NUL.
    set_limit(0);
    rd_reg(3'd3, d); check("limit_zero_clamp", d, 32'd64);
    set_limit(100);
    rd_reg(3'd3, d); check("limit_over_clamp", d, 32'd64);
    src = '{32'h4142_0051, "XYZW"};
    model_job(2, cur_lim); outq.delete(); feed();
    wr_reg(3'd0, 32'h5);
    wait_done("job2");
    rd_reg(3'd1, d); check("job2_status", d, 32'h6);
    rd_reg(3'd2, d); check("job2_charcnt", d, exp_cc);
    check("job2_pushes", outq.size(), 32'd1);
    check("job2_out0", outq[0], 32'h6162_0000);
    check("job2_left_in_fifo", inq.size(), 32'd1);
    inq.delete(); upd();

    // Toggle case with the input FIFO empty for ten cycles first.
    set_limit(1);
    rd_reg(3'd3, d); check("limit_one", d, 32'd1);
    src = '{"aBcD"};
    model_job(3, cur_lim); outq.delete();
    wr_reg(3'd0, 32'h7);
    tick(10);
    rd_reg(3'd1, d); check("job3_stalled_busy", d, 32'h1);
    check("job3_no_push_stalled", outq.size(), 32'd0);
    feed();
    wait_done("job3");
    rd_reg(3'd1, d); check("job3_status", d, 32'h2);
    rd_reg(3'd2, d); check("job3_charcnt", d, 32'd4);
    check("job3_out0", outq[0], "AbCd");

    // Output FIFO full while the word waits in STORE.
    src = '{32'h4869_2100};
    model_job(0, cur_lim); outq.delete();
    @(posedge clk); #2 out_fifo_full = 1'b1;
    feed();
    wr_reg(3'd0, 32'h1);
    tick(2); #3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_data_stable", out_fifo_data, 32'h4869_2100);
    end
    check("full_no_push", outq.size(), 32'd0);
    @(posedge clk); #2 out_fifo_full = 1'b0;
    wait_done("job4");
    check("full_one_push", outq.size(), 32'd1);
    rd_reg(3'd1, d); check("job4_status", d, 32'h6);
    rd_reg(3'd2, d); check("job4_charcnt", d, 32'd3);

    // go together with abort is not a start.
    wr_reg(3'd0, 32'h9);
    rd_reg(3'd1, d); check("go_abort_ignored", d, 32'h6);
    wr_reg(3'd1, 32'h0);
    rd_reg(3'd1, d); check("status_write_clears", d, 32'h0);

    // Abort while fetching the second word.
    set_limit(4);
    src = '{"abcd"};
    model_job(1, cur_lim); outq.delete(); feed();
    wr_reg(3'd0, 32'h3);
    tick(8);
    rd_reg(3'd1, d); check("abort_pre_busy", d, 32'h1);
    wr_reg(3'd0, 32'h8);
    rd_reg(3'd1, d); check("abort_status", d, 32'h0);
    check("abort_one_push", outq.size(), 32'd1);
    rd_reg(3'd2, d); check("abort_charcnt_kept", d, 32'd4);
    set_limit(1);
    src = '{"wxyz"};
    model_job(0, cur_lim); outq.delete();
    wr_reg(3'd0, 32'h1);
    rd_reg(3'd2, d); check("restart_charcnt_zero", d, 32'd0);
    feed();
    wait_done("job5");
    rd_reg(3'd2, d); check("restart_charcnt", d, 32'd4);
    check("restart_out0", outq[0], "wxyz");

`ifdef STRHW_SEQ_IRQ_EN
    src = '{32'h6F6B_0000};
    model_job(0, cur_lim); outq.delete(); feed();
    wr_reg(3'd0, 32'h11);
    rd_reg(3'd0, d); check("ctrl_irq_en_rb", d, 32'h10);
    k = 0; st = '0; irq_at_done = 1'b0;
    while (!st[1] && k < 100) begin
      rd_reg(3'd1, st);
      irq_at_done = irq;
      k++;
    end
    if (!st[1]) begin
      n_checks++;
      $display("FAIL irq_job_timeout: done=0 after %0d polls, required done=1", k);
    end
    check("irq_low_with_done", {31'd0, irq_at_done}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("irq_rises", {31'd0, irq}, 32'd1);
    wr_reg(3'd1, 32'h0);
    @(posedge clk); @(negedge clk);
    check("irq_falls", {31'd0, irq}, 32'd0);
`else
    wr_reg(3'd0, 32'h10);
    rd_reg(3'd0, d); check("ctrl_irq_en_rb", d, 32'h0);
`endif

    check("expected_pushes_drained", expq.size(), 32'd0);
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
